ds_sequencer: RTL and testbench
===============================

// Module: ds_sequencer
// PURPOSE
//  Initiator side of the data-stack interface: owns the TOS register and drives the stack memory
//  block's 2-bit mode and tri-state data bus to execute Forth stack primitives.
//  Sits between the instruction decoder (cmd_* handshake) and the stack memory block.
//  Tracks depth, rejects underflow/overflow, and never contends with the stack on the shared bus.
// PARAMETERS
//  WIDTH    32   data/bus width in bits
//  DEPTH    256  capacity of the attached stack memory; legal total depth is 0..DEPTH+1 (memory + TOS)
//  DEPTH_W  9    width of depth counter; must hold DEPTH+1
// PORTS
//  clock      in     1        system clock, all state updates on rising edge
//  reset_n    in     1        synchronous, active-low reset
//  cmd_valid  in     1        command request
//  cmd_op     in     4        opcode: 0 NOP,1 LIT,2 DUP,3 DROP,4 SWAP,5 OVER,6 ADD,7 SUB,8 AND,9 XOR,10 CLEAR; 11-15 illegal
//  cmd_data   in     WIDTH    literal for LIT
//  cmd_ready  out    1        high only in IDLE; command accepted when cmd_valid & cmd_ready at edge
//  tos        out    WIDTH    top-of-stack register
//  depth      out    DEPTH_W  items on stack including TOS
//  err        out    1        one-cycle pulse: command rejected (underflow, overflow, illegal op)
//  ds_mode    out    2        stack command: 00 empty, 01 push, 10 pop, 11 idle
//  ds_bus     inout  WIDTH    shared stack bus; driven with tos/temp only when ds_mode==01, else 'z
// BEHAVIOUR
//  Reset (reset_n low at edge): tos=0, depth=0, err=0, state=IDLE, cmd_ready=0 during reset,
//   ds_mode=00 combinationally while reset_n low (empties stack memory), ds_bus='z.
//  Stack protocol: push = drive ds_bus and ds_mode=01 in same cycle (sampled at edge).
//   pop = ds_mode=10 for one cycle; popped word is valid on ds_bus in the NEXT cycle (CAPTURE),
//   during which ds_mode=11 and ds_bus is not driven; word latched into nreg at end of CAPTURE.
//  States: IDLE, POP, CAPTURE, PUSH1, PUSH2, CLR. IDLE outputs ds_mode=11.
//  Per-op sequences (cycles after accept; cmd_ready low until return to IDLE):
//   NOP   : no state change, stays IDLE.
//   LIT   : needs depth<=DEPTH. if depth>0: PUSH1 (bus=old tos). tos<=cmd_data, depth+1. 0/1 busy cycles.
//   DUP   : needs 1<=depth<=DEPTH. PUSH1 (bus=tos). depth+1.
//   DROP  : needs depth>=1. if depth==1: tos<=0, depth=0, no bus cycle. else POP,CAPTURE; tos<=nreg; depth-1.
//   SWAP  : needs depth>=2. POP,CAPTURE,PUSH1(bus=tos); tos<=nreg. depth unchanged.
//   OVER  : needs 2<=depth<=DEPTH. POP,CAPTURE,PUSH1(bus=nreg),PUSH2(bus=tos); tos<=nreg; depth+1.
//   ADD/SUB/AND/XOR: needs depth>=2. POP,CAPTURE; tos<=nreg OP tos (SUB = nreg-tos); depth-1.
//   CLEAR : CLR (ds_mode=00 one cycle); tos=0, depth=0.
//  Arithmetic modulo 2^WIDTH; no carry/overflow flags.
//  Rejection: failing precondition or illegal opcode -> err=1 next cycle, no stack/bus activity,
//   tos/depth unchanged, remains IDLE. Underflow checked before overflow.
//  tos/depth update at the edge that returns to IDLE; intermediate values not visible.
//  cmd_valid while busy is ignored (not queued). reset_n low mid-sequence aborts immediately.
//  Bus safety: ds_bus driven only in PUSH1/PUSH2; never in CAPTURE or the cycle after a pop.
// TESTING
//  reset, then LIT 5, LIT 7, ADD -> tos=12, depth=1; ds_mode trace 11,01,10,11.
//  LIT 3, LIT 9, SWAP -> tos=3, next DROP -> tos=9, depth=1.
//  LIT 1, LIT 2, OVER -> tos=1, depth=3; DROP,DROP -> tos=1, depth=1.
//  depth 0: DROP, ADD -> err pulse each, tos=0, depth=0; opcode 12 -> err, no ds_mode!=11.
//  push 257 LITs (0..256) -> depth=257; 258th LIT and DUP -> err; 256 ADDs -> tos=32896 (256*257/2).
//  LIT 0, LIT 1, SUB -> tos=32'hFFFFFFFF; reset_n low during OVER -> depth=0, ds_mode=00, bus 'z.

Source files
------------

// File: rtl/ds_sequencer.sv
// ds_sequencer
//   Initiator side of the data-stack interface. Owns the top-of-stack register
//   and drives the stack memory block's 2-bit mode and the shared tri-state
//   data bus to execute Forth stack primitives issued by the instruction
//   decoder. Tracks total depth (memory + TOS) and rejects underflow, overflow
//   and illegal opcodes without touching the stack.
//
// Ports
//   clock      in    1        rising-edge clock
//   reset_n    in    1        synchronous active-low reset
//   cmd_valid  in    1        command request
//   cmd_op     in    4        0 NOP,1 LIT,2 DUP,3 DROP,4 SWAP,5 OVER,6 ADD,
//                             7 SUB,8 AND,9 XOR,10 CLEAR; 11-15 illegal
//   cmd_data   in    WIDTH    literal for LIT
//   cmd_ready  out   1        high only in IDLE (and out of reset)
//   tos        out   WIDTH    top-of-stack register
//   depth      out   DEPTH_W  items on stack including TOS
//   err        out   1        one-cycle pulse when a command is rejected
//   ds_mode    out   2        00 empty, 01 push, 10 pop, 11 idle
//   ds_bus     inout WIDTH    shared stack bus, driven only while pushing

module ds_sequencer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int DEPTH_W = 9
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  input  logic [3:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_data,
  output logic               cmd_ready,
  output logic [WIDTH-1:0]   tos,
  output logic [DEPTH_W-1:0] depth,
  output logic               err,
  output logic [1:0]         ds_mode,
  inout  wire  [WIDTH-1:0]   ds_bus
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LIT   = 4'd1;
  localparam logic [3:0] OP_DUP   = 4'd2;
  localparam logic [3:0] OP_DROP  = 4'd3;
  localparam logic [3:0] OP_SWAP  = 4'd4;
  localparam logic [3:0] OP_OVER  = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd6;
  localparam logic [3:0] OP_SUB   = 4'd7;
  localparam logic [3:0] OP_AND   = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_CLEAR = 4'd10;

  localparam logic [1:0] MODE_EMPTY = 2'b00;
  localparam logic [1:0] MODE_PUSH  = 2'b01;
  localparam logic [1:0] MODE_POP   = 2'b10;
  localparam logic [1:0] MODE_IDLE  = 2'b11;

  // Largest depth from which one more item may still be added.
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] ONE       = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] TWO       = DEPTH_W'(2);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPTURE,
    PUSH1,
    PUSH2,
    CLR
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     tos_q, tos_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic                 err_q, err_d;
  logic [WIDTH-1:0]     nreg_q, nreg_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     lit_q, lit_d;

  logic [WIDTH-1:0]     popWord;
  logic [WIDTH-1:0]     aluResult;
  logic [WIDTH-1:0]     pushData;
  logic                 pushEn;

  // The popped word is only valid on the bus during CAPTURE; everything that
  // consumes it reads popWord in that state.
  assign popWord = ds_bus;

  // Binary ops combine the second item (just popped) with TOS; SUB is
  // second-minus-top as in Forth.
  always_comb begin
    aluResult = popWord;
    case (op_q)
      OP_ADD:  aluResult = popWord + tos_q;
      OP_SUB:  aluResult = popWord - tos_q;
      OP_AND:  aluResult = popWord & tos_q;
      OP_XOR:  aluResult = popWord ^ tos_q;
      default: aluResult = popWord;
    endcase
  end

  // Next-state logic. Commands are decoded only in IDLE, so anything on the
  // command port while busy is simply ignored. tos/depth change only on the
  // edge that returns to IDLE so no intermediate value is ever visible.
  always_comb begin
    state_d = state_q;
    tos_d   = tos_q;
    depth_d = depth_q;
    err_d   = 1'b0;
    nreg_d  = nreg_q;
    op_d    = op_q;
    lit_d   = lit_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          lit_d = cmd_data;
          case (cmd_op)
            OP_NOP: begin
            end
            OP_LIT: begin
              if (depth_q > DEPTH_MAX) begin
                err_d = 1'b1;
              end else if (depth_q == '0) begin
                // Empty stack: the literal goes straight into TOS.
                tos_d   = cmd_data;
                depth_d = ONE;
              end else begin
                state_d = PUSH1;
              end
            end
            OP_DUP: begin
              if (depth_q == '0 || depth_q > DEPTH_MAX) begin
                err_d = 1'b1;
              end else begin
                state_d = PUSH1;
              end
            end
            OP_DROP: begin
              if (depth_q == '0) begin
                err_d = 1'b1;
              end else if (depth_q == ONE) begin
                // Only TOS holds data; memory is already empty.
                tos_d   = '0;
                depth_d = '0;
              end else begin
                state_d = POP;
              end
            end
            OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
              if (depth_q < TWO) begin
                err_d = 1'b1;
              end else begin
                state_d = POP;
              end
            end
            OP_OVER: begin
              if (depth_q < TWO || depth_q > DEPTH_MAX) begin
                err_d = 1'b1;
              end else begin
                state_d = POP;
              end
            end
            OP_CLEAR: begin
              state_d = CLR;
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end

      POP: begin
        state_d = CAPTURE;
      end

      CAPTURE: begin
        nreg_d = popWord;
        case (op_q)
          OP_SWAP, OP_OVER: begin
            state_d = PUSH1;
          end
          OP_DROP: begin
            tos_d   = popWord;
            depth_d = depth_q - ONE;
            state_d = IDLE;
          end
          default: begin
            tos_d   = aluResult;
            depth_d = depth_q - ONE;
            state_d = IDLE;
          end
        endcase
      end

      PUSH1: begin
        if (op_q == OP_OVER) begin
          state_d = PUSH2;
        end else begin
          state_d = IDLE;
          case (op_q)
            OP_LIT: begin
              tos_d   = lit_q;
              depth_d = depth_q + ONE;
            end
            OP_DUP: begin
              depth_d = depth_q + ONE;
            end
            default: begin
              // SWAP: old TOS went to memory, old second becomes TOS.
              tos_d = nreg_q;
            end
          endcase
        end
      end

      PUSH2: begin
        tos_d   = nreg_q;
        depth_d = depth_q + ONE;
        state_d = IDLE;
      end

      CLR: begin
        tos_d   = '0;
        depth_d = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset aborts any
  // sequence in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tos_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      nreg_q  <= '0;
      op_q    <= OP_NOP;
      lit_q   <= '0;
    end else begin
      state_q <= state_d;
      tos_q   <= tos_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      nreg_q  <= nreg_d;
      op_q    <= op_d;
      lit_q   <= lit_d;
    end
  end

  // Stack mode decode. While reset_n is low the memory is told to empty
  // itself so both sides come out of reset agreeing on depth 0.
  always_comb begin
    ds_mode = MODE_IDLE;
    if (!reset_n) begin
      ds_mode = MODE_EMPTY;
    end else begin
      case (state_q)
        POP:          ds_mode = MODE_POP;
        PUSH1, PUSH2: ds_mode = MODE_PUSH;
        CLR:          ds_mode = MODE_EMPTY;
        default:      ds_mode = MODE_IDLE;
      endcase
    end
  end

  // Push data: OVER first pushes the captured second item back, then the old
  // TOS; every other push writes TOS.
  always_comb begin
    pushData = tos_q;
    if (state_q == PUSH1 && op_q == OP_OVER) begin
      pushData = nreg_q;
    end
  end

  // Bus is driven only during a push, which keeps it released during CAPTURE
  // when the memory drives the popped word.
  assign pushEn = (ds_mode == MODE_PUSH);
  assign ds_bus = pushEn ? pushData : {WIDTH{1'bz}};

  assign cmd_ready = reset_n && (state_q == IDLE);
  assign tos       = tos_q;
  assign depth     = depth_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ds_sequencer.sv
// tb_ds_sequencer
//   Testbench for ds_sequencer. Contains a behavioural stack memory attached
//   to the shared bus, a queue-based reference model of the Forth stack, a
//   driver that pushes expected results into a scoreboard, and a monitor that
//   compares them when each command completes.

module tb_ds_sequencer;

  localparam int W  = 32;
  localparam int D  = 256;
  localparam int DW = 9;

  logic          clock     = 1'b0;
  logic          reset_n   = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [3:0]    cmd_op    = 4'd0;
  logic [W-1:0]  cmd_data  = '0;
  wire           cmd_ready;
  wire  [W-1:0]  tos;
  wire  [DW-1:0] depth;
  wire           err;
  wire  [1:0]    ds_mode;
  wire  [W-1:0]  dsBus;

  int vectors     = 0;
  int miscompares = 0;
  logic monitorOff = 1'b0;

  typedef struct {
    logic          err;
    logic [W-1:0]  tos;
    logic [DW-1:0] depth;
  } expT;

  expT expQ[$];

  // Reference model: the whole stack as a queue, last element is TOS.
  logic [W-1:0] model[$];

  // Behavioural stack memory on the far side of the bus.
  logic [W-1:0] memStack[$];
  logic [W-1:0] memData  = '0;
  logic         memDrive = 1'b0;

  logic [1:0]   modeLog[$];

  ds_sequencer #(.WIDTH(W), .DEPTH(D), .DEPTH_W(DW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .tos       (tos),
    .depth     (depth),
    .err       (err),
    .ds_mode   (ds_mode),
    .ds_bus    (dsBus)
  );

  always #5 clock = ~clock;

  assign dsBus = memDrive ? memData : {W{1'bz}};

  // Shared comparison helper used by both the monitor and the main sequence.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Stack memory: push samples the bus at the edge, pop presents the word
  // during the following cycle, empty discards everything.
  always @(posedge clock) begin
    memDrive <= 1'b0;
    case (ds_mode)
      2'b00: memStack.delete();
      2'b01: begin
        if (memStack.size() >= D) begin
          miscompares++;
          $display("[TB] FAIL memOverflow: got push at size %0d, expected size below %0d",
                   memStack.size(), D);
        end else begin
          memStack.push_back(dsBus);
        end
      end
      2'b10: begin
        if (memStack.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL memUnderflow: got pop at size 0, expected nonzero size");
        end else begin
          memData  <= memStack.pop_back();
          memDrive <= 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bus safety: while the memory is returning a popped word the sequencer
  // must be idle on the stack interface and therefore not driving.
  always @(negedge clock) begin
    if (reset_n && ds_mode != 2'b11) modeLog.push_back(ds_mode);
    if (reset_n && memDrive && ds_mode != 2'b11) begin
      miscompares++;
      $display("[TB] FAIL busContention: got ds_mode %0b during capture, expected 11", ds_mode);
    end
  end

  // Applies one command to the reference model; returns 1 when rejected.
  function automatic logic applyModel(input logic [3:0] op, input logic [W-1:0] data);
    int n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    n = model.size();
    case (op)
      4'd0: return 1'b0;
      4'd1: begin
        if (n > D) return 1'b1;
        model.push_back(data);
      end
      4'd2: begin
        if (n < 1 || n > D) return 1'b1;
        model.push_back(model[n-1]);
      end
      4'd3: begin
        if (n < 1) return 1'b1;
        void'(model.pop_back());
      end
      4'd4: begin
        if (n < 2) return 1'b1;
        a = model[n-1];
        model[n-1] = model[n-2];
        model[n-2] = a;
      end
      4'd5: begin
        if (n < 2 || n > D) return 1'b1;
        model.push_back(model[n-2]);
      end
      4'd6, 4'd7, 4'd8, 4'd9: begin
        if (n < 2) return 1'b1;
        b = model.pop_back();
        a = model.pop_back();
        case (op)
          4'd6:    model.push_back(a + b);
          4'd7:    model.push_back(a - b);
          4'd8:    model.push_back(a & b);
          default: model.push_back(a ^ b);
        endcase
      end
      4'd10: model.delete();
      default: return 1'b1;
    endcase
    return 1'b0;
  endfunction

  // Issues one command: records the model's expectation, holds junk on the
  // command port while the sequencer is busy, and returns at the negedge on
  // which the sequencer is ready again.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] data);
    expT e;
    int guard;
    guard = 0;
    @(negedge clock);
    while (!cmd_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    e.err   = applyModel(op, data);
    e.tos   = (model.size() > 0) ? model[model.size()-1] : '0;
    e.depth = DW'(model.size());
    expQ.push_back(e);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clock);
    #1;
    cmd_valid = !cmd_ready;
    cmd_op    = 4'($urandom);
    cmd_data  = $urandom;
    guard = 0;
    @(negedge clock);
    while (!cmd_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    cmd_valid = 1'b0;
  endtask

  // Monitor: on each accepted command, compare err on the next cycle and
  // tos/depth once the sequencer returns to IDLE.
  initial begin
    expT e;
    int cnt;
    forever begin
      @(posedge clock);
      if (reset_n && cmd_valid && cmd_ready && !monitorOff) begin
        @(negedge clock);
        if (expQ.size() == 0) begin
          checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd1);
        end else begin
          e = expQ.pop_front();
          checkOutput("err", 64'(err), 64'(e.err));
          cnt = 0;
          while (!cmd_ready && cnt < 20) begin
            @(negedge clock);
            cnt++;
          end
          checkOutput("completion", 64'(cmd_ready), 64'd1);
          checkOutput("tos", 64'(tos), 64'(e.tos));
          checkOutput("depth", 64'(depth), 64'(e.depth));
        end
      end
    end
  end

  initial begin
    #2000000;
    miscompares++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    logic [63:0] trace;
    logic [3:0] rop;

    // Reset behaviour: memory emptied, no handshake, registers cleared.
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("resetReady", 64'(cmd_ready), 64'd0);
    checkOutput("resetMode", 64'(ds_mode), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("resetTos", 64'(tos), 64'd0);
    checkOutput("resetDepth", 64'(depth), 64'd0);
    checkOutput("resetErr", 64'(err), 64'd0);
    checkOutput("idleMode", 64'(ds_mode), 64'd3);

    // LIT 5, LIT 7, ADD: one push then one pop on the stack interface.
    modeLog.delete();
    applyStimulus(4'd1, 32'd5);
    applyStimulus(4'd1, 32'd7);
    applyStimulus(4'd6, 32'd0);
    checkOutput("addTos", 64'(tos), 64'd12);
    checkOutput("addDepth", 64'(depth), 64'd1);
    trace = 64'(modeLog.size());
    foreach (modeLog[i]) trace = {trace[61:0], modeLog[i]};
    checkOutput("modeTrace", trace, {60'd2, 2'b01, 2'b10});

    // SWAP then DROP.
    applyStimulus(4'd10, 32'd0);
    applyStimulus(4'd1, 32'd3);
    applyStimulus(4'd1, 32'd9);
    applyStimulus(4'd4, 32'd0);
    checkOutput("swapTos", 64'(tos), 64'd3);
    applyStimulus(4'd3, 32'd0);
    checkOutput("swapDropTos", 64'(tos), 64'd9);
    checkOutput("swapDropDepth", 64'(depth), 64'd1);

    // OVER then two DROPs.
    applyStimulus(4'd10, 32'd0);
    applyStimulus(4'd1, 32'd1);
    applyStimulus(4'd1, 32'd2);
    applyStimulus(4'd5, 32'd0);
    checkOutput("overTos", 64'(tos), 64'd1);
    checkOutput("overDepth", 64'(depth), 64'd3);
    applyStimulus(4'd3, 32'd0);
    applyStimulus(4'd3, 32'd0);
    checkOutput("overDropTos", 64'(tos), 64'd1);
    checkOutput("overDropDepth", 64'(depth), 64'd1);

    // Underflow and illegal opcode on an empty stack: no stack traffic.
    applyStimulus(4'd10, 32'd0);
    modeLog.delete();
    applyStimulus(4'd3, 32'd0);
    applyStimulus(4'd6, 32'd0);
    applyStimulus(4'd12, 32'd0);
    checkOutput("rejectTraffic", 64'(modeLog.size()), 64'd0);
    checkOutput("rejectDepth", 64'(depth), 64'd0);

    // Fill to DEPTH+1, overflow rejects, then fold back with ADDs.
    for (int i = 0; i <= D; i++) applyStimulus(4'd1, W'(i));
    checkOutput("fullDepth", 64'(depth), 64'd257);
    applyStimulus(4'd1, 32'd999);
    applyStimulus(4'd2, 32'd0);
    for (int i = 0; i < D; i++) applyStimulus(4'd6, 32'd0);
    checkOutput("sumTos", 64'(tos), 64'd32896);
    checkOutput("sumDepth", 64'(depth), 64'd1);

    // Wrap-around subtraction.
    applyStimulus(4'd10, 32'd0);
    applyStimulus(4'd1, 32'd0);
    applyStimulus(4'd1, 32'd1);
    applyStimulus(4'd7, 32'd0);
    checkOutput("subWrap", 64'(tos), 64'hFFFFFFFF);

    // Random mix, biased towards LIT so the stack has something to work on.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 35) rop = 4'd1;
      else rop = 4'($urandom_range(0, 15));
      applyStimulus(rop, $urandom);
    end

    // Reset in the middle of OVER aborts it at once.
    applyStimulus(4'd10, 32'd0);
    applyStimulus(4'd1, 32'd4);
    applyStimulus(4'd1, 32'd8);
    monitorOff = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = 4'd5;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    @(negedge clock);
    checkOutput("overPopMode", 64'(ds_mode), 64'd2);
    reset_n = 1'b0;
    #1;
    checkOutput("abortMode", 64'(ds_mode), 64'd0);
    checkOutput("abortMemDrive", 64'(memDrive), 64'd0);
    @(negedge clock);
    checkOutput("abortDepth", 64'(depth), 64'd0);
    checkOutput("abortTos", 64'(tos), 64'd0);
    checkOutput("abortReady", 64'(cmd_ready), 64'd0);
    reset_n = 1'b1;
    model.delete();
    @(negedge clock);
    monitorOff = 1'b0;
    checkOutput("memEmptyAfterReset", 64'(memStack.size()), 64'd0);
    applyStimulus(4'd1, 32'd77);
    applyStimulus(4'd2, 32'd0);
    checkOutput("postResetDepth", 64'(depth), 64'd2);

    repeat (4) @(negedge clock);
    checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
